// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-requester Wishbone arbiter: FSM states and the
// next-state rule used by the arbiter core.
package wshb_arb_pkg;

    localparam int NB_REQ = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_MIRE = 2'd2
    } arb_state_t;

    // Current owner keeps the bus while it holds cyc; otherwise hand over,
    // breaking a tie in favour of whoever was not served last.
    function automatic arb_state_t arb_next(input arb_state_t state,
                                            input logic       cyc_vga,
                                            input logic       cyc_mire,
                                            input logic       last_served);
        arb_state_t nxt;
        nxt = IDLE;
        case (state)
            GNT_VGA:  nxt = cyc_vga  ? GNT_VGA  : (cyc_mire ? GNT_MIRE : IDLE);
            GNT_MIRE: nxt = cyc_mire ? GNT_MIRE : (cyc_vga  ? GNT_VGA  : IDLE);
            default: begin
                if (cyc_vga && cyc_mire)
                    nxt = last_served ? GNT_VGA : GNT_MIRE;
                else if (cyc_vga)
                    nxt = GNT_VGA;
                else if (cyc_mire)
                    nxt = GNT_MIRE;
                else
                    nxt = IDLE;
            end
        endcase
        return nxt;
    endfunction

    function automatic logic [NB_REQ-1:0] onehot_of(input arb_state_t state);
        case (state)
            GNT_VGA:  return 2'b01;
            GNT_MIRE: return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle, byte-parameterised, with master and slave views.
interface wshb_if #(parameter int DATA_BYTES = 4) ();
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [31:0]               adr;
    logic [DATA_BYTES-1:0]     sel;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic                      ack;
    logic                      err;
    logic                      rty;
    logic [2:0]                cti;
    logic [1:0]                bte;

    modport master (output cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    input  dat_sm, ack, err, rty);
    modport slave  (input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one Wishbone master port between
// the VGA reader (requester 0) and the pattern writer (requester 1).
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int FIRST_GNT  = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    wshb_if.slave             wshb_ifs_vga,
    wshb_if.slave             wshb_ifs_mire,
    wshb_if.master            wshb_ifm,
    output logic [NB_REQ-1:0] grant
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_served;

    assign state_next = arb_next(state, wshb_ifs_vga.cyc, wshb_ifs_mire.cyc, last_served);

    // Reset seeds last_served with the other index so the first tie goes to FIRST_GNT.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            last_served <= (FIRST_GNT == 0) ? 1'b1 : 1'b0;
        end else begin
            state <= state_next;
            grant <= onehot_of(state_next);
            if (state_next != IDLE && state_next != state)
                last_served <= (state_next == GNT_MIRE);
        end
    end

    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = 32'h0;
        wshb_ifm.sel    = {DATA_BYTES{1'b0}};
        wshb_ifm.dat_ms = {8*DATA_BYTES{1'b0}};
        wshb_ifm.cti    = 3'b000;
        wshb_ifm.bte    = 2'b00;

        wshb_ifs_vga.dat_sm  = wshb_ifm.dat_sm;
        wshb_ifs_vga.ack     = 1'b0;
        wshb_ifs_vga.err     = 1'b0;
        wshb_ifs_vga.rty     = 1'b0;
        wshb_ifs_mire.dat_sm = wshb_ifm.dat_sm;
        wshb_ifs_mire.ack    = 1'b0;
        wshb_ifs_mire.err    = 1'b0;
        wshb_ifs_mire.rty    = 1'b0;

        if (grant[0]) begin
            wshb_ifm.cyc     = wshb_ifs_vga.cyc;
            wshb_ifm.stb     = wshb_ifs_vga.stb;
            wshb_ifm.we      = wshb_ifs_vga.we;
            wshb_ifm.adr     = wshb_ifs_vga.adr;
            wshb_ifm.sel     = wshb_ifs_vga.sel;
            wshb_ifm.dat_ms  = wshb_ifs_vga.dat_ms;
            wshb_ifm.cti     = wshb_ifs_vga.cti;
            wshb_ifm.bte     = wshb_ifs_vga.bte;
            wshb_ifs_vga.ack = wshb_ifm.ack;
            wshb_ifs_vga.err = wshb_ifm.err;
            wshb_ifs_vga.rty = wshb_ifm.rty;
        end else if (grant[1]) begin
            wshb_ifm.cyc      = wshb_ifs_mire.cyc;
            wshb_ifm.stb      = wshb_ifs_mire.stb;
            wshb_ifm.we       = wshb_ifs_mire.we;
            wshb_ifm.adr      = wshb_ifs_mire.adr;
            wshb_ifm.sel      = wshb_ifs_mire.sel;
            wshb_ifm.dat_ms   = wshb_ifs_mire.dat_ms;
            wshb_ifm.cti      = wshb_ifs_mire.cti;
            wshb_ifm.bte      = wshb_ifs_mire.bte;
            wshb_ifs_mire.ack = wshb_ifm.ack;
            wshb_ifs_mire.err = wshb_ifm.err;
            wshb_ifs_mire.rty = wshb_ifm.rty;
        end
    end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter DATA_BYTES, default 4: byte width of all three Wishbone ports.
REQ-002 Parameter FIRST_GNT, default 0: master index that wins the first tie after reset.
REQ-003 sys_clk  input  1  system clock (100 MHz); one clock, all logic on its rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wshb_ifs_vga  wshb_if.slave  DATA_BYTES  requester 0: VGA frame reader (read-only in practice).
REQ-006 wshb_ifs_mire  wshb_if.slave  DATA_BYTES  requester 1: pattern/image writer.
REQ-007 wshb_ifm  wshb_if.master  DATA_BYTES  shared port toward the SDRAM slave.
REQ-008 grant  output  2  one-hot registered grant; 2'b00 when idle; bit0 = VGA, bit1 = writer.

Function
REQ-009 FSM states: IDLE, GNT_VGA, GNT_MIRE; state register is the only source of grant.
REQ-010 IDLE, one cyc high: go to that requester's GNT state at the next edge.
REQ-011 IDLE, both cyc high: grant the requester not served last (round-robin).
REQ-012 IDLE, no cyc: stay in IDLE.
REQ-013 GNT_x while cyc_x high: hold, regardless of the other requester's cyc; no preemption.
REQ-014 GNT_x with cyc_x low and the other cyc high: go directly to the other GNT state at the next edge, no IDLE cycle.
REQ-015 GNT_x with both cyc low: go to IDLE.
REQ-016 last_served register updates on every entry into a GNT state.
REQ-017 Grant latency: cyc asserted at edge N from IDLE -> cyc/stb visible on wshb_ifm in cycle N+1.
REQ-018 Granted: cyc, stb, we, adr, sel, dat_ms, cti, bte of the granted requester drive wshb_ifm combinationally from the registered grant.
REQ-019 Not granted (IDLE): wshb_ifm drives cyc=0, stb=0, we=0, adr=0, sel=0, dat_ms=0, cti=0, bte=0.
REQ-020 ack, err, rty from wshb_ifm route only to the granted requester; the non-granted requester sees ack=err=rty=0.
REQ-021 dat_sm broadcasts to both requesters; only the granted requester's ack qualifies it.
REQ-022 The cycle in which cyc_x falls forwards cyc=0 to wshb_ifm; an ack arriving that cycle routes to x.
REQ-023 No combinational path from any cyc to grant; the FSM uses cyc values sampled at the edge.

Reset
REQ-024 Assertion of sys_rst_n low forces state=IDLE, grant=2'b00, and last_served = !FIRST_GNT, immediately and asynchronously.
REQ-025 Reset mid-transfer: wshb_ifm outputs drop to the REQ-019 values in the same cycle; in-flight acks are discarded.
REQ-026 Deassertion is synchronised by the instantiating level; no internal synchroniser is required.

Structure
REQ-027 Shared package wshb_arb_pkg: enum arb_state_t {IDLE, GNT_VGA, GNT_MIRE}, localparam NB_REQ = 2.
REQ-028 Single module with no sub-modules; FSM in one always_ff, muxing in one always_comb.
REQ-029 Instantiated in Top between vga/mire and wshb_if_sdram, replacing the direct vga->SDRAM connection.

Verification
REQ-030 Reset, then VGA cyc=1 at cycle 3 -> grant=01 at cycle 4; adr 0x100 passes through; ack reaches VGA only.
REQ-031 Both cyc rise in the same cycle after reset (FIRST_GNT=0) -> VGA granted; after VGA drops cyc -> writer granted next edge, grant 01->10 with no 00 gap.
REQ-032 Writer holds cyc for 64 cycles of burst, VGA requesting throughout -> grant stays 10 for all 64 cycles; VGA ack=0 throughout; VGA granted on the edge after the writer's cyc falls.
REQ-033 Alternating back-to-back requests, both always pending -> grant sequence 01,10,01,10; no requester granted twice consecutively.
REQ-034 sys_rst_n pulsed low mid-burst with stb=1 -> wshb_ifm.cyc=0 the same cycle; grant=00; after release the first tie goes to VGA.
REQ-035 Idle for 10 cycles -> all wshb_ifm outputs 0, grant=00; injected slave ack=1 reaches neither requester.
